mar_stack_reg: RTL



---
 rtl/mar_stack_reg_pkg.sv | 19 +
 rtl/mar_stack_reg_if.sv | 34 +++
 rtl/mar_stack_reg_lifo.sv | 55 +++++
 rtl/mar_stack_reg.sv | 117 +++++++++++
 4 files changed

// File: rtl/mar_stack_reg_pkg.sv
// rtl/mar_stack_reg_pkg.sv - mode encodings and default sizes shared by the address register slice
package mar_pkg;

   typedef enum logic [2:0] {
      MODE_CLEAR = 3'b000,
      MODE_LOAD  = 3'b001,
      MODE_DRIVE = 3'b010,
      MODE_HOLD  = 3'b011,
      MODE_INC   = 3'b100,
      MODE_DEC   = 3'b101,
      MODE_PUSH  = 3'b110,
      MODE_POP   = 3'b111
   } mar_mode_e;

   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_DEPTH  = 4;
   localparam int DEFAULT_STRIDE = 4;

endpackage

// File: rtl/mar_stack_reg_if.sv
// rtl/mar_stack_reg_if.sv - sequencer-side mode input and address/stack status outputs
// Optional MAR_ALIGN_CHECK_EN adds the misaligned status signal.
interface mar_stack_reg_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [2:0]       register_mode;
   logic [WIDTH-1:0] register_value;
   logic             bus_oe;
   logic [CW-1:0]    stack_count;
   logic             stack_full;
   logic             stack_empty;
   logic             overflow;
   logic             underflow;
`ifdef MAR_ALIGN_CHECK_EN
   logic             misaligned;

   modport master (output register_mode,
                   input  register_value, bus_oe, stack_count, stack_full,
                          stack_empty, overflow, underflow, misaligned);
   modport slave  (input  register_mode,
                   output register_value, bus_oe, stack_count, stack_full,
                          stack_empty, overflow, underflow, misaligned);
`else
   modport master (output register_mode,
                   input  register_value, bus_oe, stack_count, stack_full,
                          stack_empty, overflow, underflow);
   modport slave  (input  register_mode,
                   output register_value, bus_oe, stack_count, stack_full,
                          stack_empty, overflow, underflow);
`endif
endinterface

// File: rtl/mar_stack_reg_lifo.sv
// rtl/mar_stack_reg_lifo.sv - DEPTH x WIDTH shadow stack with count, full and empty
module mar_lifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_top,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_rd_idx;
   logic             w_full;
   logic             w_empty;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);
   // When full the write index aliases slot 0, but writes are blocked then.
   assign w_wr_idx = r_count[AW-1:0];
   assign w_rd_idx = w_wr_idx - AW'(1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_push && !w_full) begin
         r_count <= r_count + CW'(1);
      end else if (i_pop && !w_empty) begin
         r_count <= r_count - CW'(1);
      end
   end

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clock) begin
      if (i_push && !w_full) begin
         r_mem[w_wr_idx] <= i_data;
      end
   end

   assign o_top   = r_mem[w_rd_idx];
   assign o_count = r_count;
   assign o_full  = w_full;
   assign o_empty = w_empty;
endmodule

// File: rtl/mar_stack_reg.sv
// rtl/mar_stack_reg.sv - memory address register with stride inc/dec, shadow stack and bus tri-state
// Optional MAR_ALIGN_CHECK_EN registers a misaligned flag on LOAD/POP.
module mar_stack_reg
   import mar_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int STRIDE = DEFAULT_STRIDE
) (
   input  logic             clock,
   input  logic             reset_n,
   inout  wire  [WIDTH-1:0] data_bus,
   mar_stack_reg_if.slave   bus_if
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_value;
   logic             r_overflow;
   logic             r_underflow;
   logic             w_clear;
   logic             w_push;
   logic             w_pop;
   logic             w_drive;
   logic [WIDTH-1:0] w_top;
   logic [CW-1:0]    w_count;
   logic             w_full;
   logic             w_empty;

   // Unknown mode codes fall into the default arm: HOLD with the bus released.
   always_comb begin
      w_clear = 1'b0;
      w_push  = 1'b0;
      w_pop   = 1'b0;
      w_drive = 1'b0;
      case (bus_if.register_mode)
         MODE_CLEAR: w_clear = 1'b1;
         MODE_DRIVE: w_drive = reset_n;
         MODE_PUSH:  w_push  = 1'b1;
         MODE_POP:   w_pop   = 1'b1;
         default:    ;
      endcase
   end

   assign data_bus = w_drive ? r_value : {WIDTH{1'bz}};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_value     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         case (bus_if.register_mode)
            MODE_CLEAR: begin
               r_value     <= '0;
               r_overflow  <= 1'b0;
               r_underflow <= 1'b0;
            end
            MODE_LOAD:  r_value <= data_bus;
            MODE_INC:   r_value <= r_value + WIDTH'(STRIDE);
            MODE_DEC:   r_value <= r_value - WIDTH'(STRIDE);
            MODE_PUSH: begin
               if (w_full) r_overflow <= 1'b1;
            end
            MODE_POP: begin
               if (w_empty) r_underflow <= 1'b1;
               else         r_value     <= w_top;
            end
            default:    ;
         endcase
      end
   end

`ifdef MAR_ALIGN_CHECK_EN
   logic r_misaligned;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_misaligned <= 1'b0;
      end else begin
         case (bus_if.register_mode)
            MODE_CLEAR: r_misaligned <= 1'b0;
            MODE_LOAD:  r_misaligned <= ((data_bus % WIDTH'(STRIDE)) != '0);
            MODE_POP: begin
               if (!w_empty) r_misaligned <= ((w_top % WIDTH'(STRIDE)) != '0);
            end
            default:    ;
         endcase
      end
   end

   assign bus_if.misaligned = r_misaligned;
`endif

   mar_lifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lifo (
      .clock   (clock),
      .reset_n (reset_n),
      .i_clear (w_clear),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (r_value),
      .o_top   (w_top),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus_if.register_value = r_value;
   assign bus_if.bus_oe         = w_drive;
   assign bus_if.stack_count    = w_count;
   assign bus_if.stack_full     = w_full;
   assign bus_if.stack_empty    = w_empty;
   assign bus_if.overflow       = r_overflow;
   assign bus_if.underflow      = r_underflow;
endmodule
